// File: rtl/spi_slave_regs_pkg.sv
// Shared constants for the SPI brightness-register slave: field widths, chip-select
// polarity, opcodes and FSM state encodings.
package spi_slave_regs_pkg;

  localparam int DEF_CMD_BITS     = 8;
  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_PAYLOAD_BITS = 8;
  localparam int BRIGHTNESS_WIDTH = 8;
  localparam int DEF_NUM_REGS     = 4;

  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;
  localparam logic [7:0] DEF_CMD_READ  = 8'h03;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMMAND = 3'd1;
  localparam logic [2:0] ST_ADDRESS = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_IGNORE  = 3'd5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_slave_regs_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer for an asynchronous level with registered
// single-cycle rise/fall pulses (3 sysclk from pin to pulse).
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/spi_slave_regs.sv
// SPI Mode 0 slave exposing a small brightness register bank (cmd, addr, payload; MSB first).
// Optional error counter output o_err_cnt is enabled by defining SPI_SLAVE_ERR_CNT_EN.
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int CMD_BITS     = DEF_CMD_BITS,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter logic [CMD_BITS-1:0] CMD_WRITE = DEF_CMD_WRITE,
  parameter logic [CMD_BITS-1:0] CMD_READ  = DEF_CMD_READ
) (
  input  logic                             sysclk,
  input  logic                             rst_n,
  input  logic                             sclk,
  input  logic                             cs,
  input  logic                             mosi,
  output logic                             miso,
  output logic [NUM_REGS*PAYLOAD_BITS-1:0] o_regs,
  output logic                             o_wr_strobe,
  output logic [ADDR_BITS-1:0]             o_wr_addr,
`ifdef SPI_SLAVE_ERR_CNT_EN
  output logic [7:0]                       o_err_cnt,
`endif
  output logic                             o_busy
);

  localparam int MAX_BITS = max3(CMD_BITS, ADDR_BITS, PAYLOAD_BITS);
  localparam int CNT_W    = $clog2(MAX_BITS) + 1;
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic cs_m, cs_s, mosi_m, mosi_s;
  logic sclk_rise, sclk_fall;
  logic cs_active, rise_g, fall_g, armed;

  logic [2:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [MAX_BITS-2:0]     shreg;
  logic [MAX_BITS-1:0]     next_shift;
  logic [ADDR_BITS-1:0]    addr;
  logic                    addr_ok, is_read;
  logic [PAYLOAD_BITS-1:0] tx;
  logic [PAYLOAD_BITS-1:0] regs [NUM_REGS];

  logic cmd_last, addr_last, pay_last, cmd_ok, addr_in;

  // cs resets to the asserted level so a frame already in flight at reset is not picked up
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_m   <= CS_ASSERT;
      cs_s   <= CS_ASSERT;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      cs_m   <= cs;
      cs_s   <= cs_m;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  spi_sync_edge u_sclk_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .din   (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign cs_active  = (cs_s == CS_ASSERT);
  assign rise_g     = sclk_rise & cs_active;
  assign fall_g     = sclk_fall & cs_active;
  assign next_shift = {shreg, mosi_s};
  assign cmd_last   = (cnt == CNT_W'(CMD_BITS - 1));
  assign addr_last  = (cnt == CNT_W'(ADDR_BITS - 1));
  assign pay_last   = (cnt == CNT_W'(PAYLOAD_BITS - 1));
  assign cmd_ok     = (next_shift[CMD_BITS-1:0] == CMD_WRITE) ||
                      (next_shift[CMD_BITS-1:0] == CMD_READ);
  assign addr_in    = (next_shift[ADDR_BITS-1:0] < ADDR_BITS'(NUM_REGS));
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      addr        <= '0;
      addr_ok     <= 1'b0;
      is_read     <= 1'b0;
      tx          <= '0;
      miso        <= 1'b0;
      armed       <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      o_wr_strobe <= 1'b0;
      armed       <= armed | ~cs_active;
      if (state != ST_IDLE && !cs_active) begin
        state <= ST_IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            miso <= 1'b0;
            cnt  <= '0;
            if (cs_active && armed) state <= ST_COMMAND;
          end
          ST_COMMAND: if (rise_g) begin
            shreg <= next_shift[MAX_BITS-2:0];
            if (cmd_last) begin
              cnt     <= '0;
              is_read <= (next_shift[CMD_BITS-1:0] == CMD_READ);
              state   <= cmd_ok ? ST_ADDRESS : ST_IGNORE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ADDRESS: if (rise_g) begin
            shreg <= next_shift[MAX_BITS-2:0];
            if (addr_last) begin
              cnt     <= '0;
              addr    <= next_shift[ADDR_BITS-1:0];
              addr_ok <= addr_in;
              tx      <= addr_in ? regs[next_shift[IDX_W-1:0]] : '0;
              state   <= ST_PAYLOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PAYLOAD: begin
            if (fall_g && is_read) begin
              miso <= tx[PAYLOAD_BITS-1];
              tx   <= {tx[PAYLOAD_BITS-2:0], 1'b0};
            end
            if (rise_g) begin
              shreg <= next_shift[MAX_BITS-2:0];
              if (pay_last) begin
                cnt   <= '0;
                miso  <= 1'b0;
                state <= ST_DONE;
                if (!is_read && addr_ok) begin
                  regs[addr[IDX_W-1:0]] <= next_shift[PAYLOAD_BITS-1:0];
                  o_wr_addr             <= addr;
                  o_wr_strobe           <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_DONE, ST_IGNORE: miso <= 1'b0;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs[g*PAYLOAD_BITS +: PAYLOAD_BITS] = regs[g];
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic err_abort, err_cmd, err_addr;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // An abort only counts while the frame is still undecided; IGNORE was already counted
  assign err_abort = !cs_active && (state == ST_COMMAND || state == ST_ADDRESS ||
                                    state == ST_PAYLOAD);
  assign err_cmd   = cs_active && rise_g && (state == ST_COMMAND) && cmd_last && !cmd_ok;
  assign err_addr  = cs_active && rise_g && (state == ST_ADDRESS) && addr_last && !addr_in;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) o_err_cnt <= 8'h00;
    else if (err_abort || err_cmd || err_addr) o_err_cnt <= sat_inc8(o_err_cnt);
  end
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: directed frames from the test plan followed by
// randomized frames checked against a frame-level register model.
module tb_spi_slave_regs;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sclk   = 1'b0;
  logic        cs     = 1'b1;
  logic        mosi   = 1'b0;
  logic        miso;
  logic [31:0] o_regs;
  logic        o_wr_strobe;
  logic [7:0]  o_wr_addr;
  logic        o_busy;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0]  o_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] mregs [4];
  int merr = 0;

  spi_slave_regs dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .o_regs      (o_regs),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr),
`ifdef SPI_SLAVE_ERR_CNT_EN
    .o_err_cnt   (o_err_cnt),
`endif
    .o_busy      (o_busy)
  );

  always #4 sysclk = ~sysclk;

  always @(posedge sysclk) if (o_wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_regs();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  // Frame-level error accounting: abort before DONE, bad opcode, bad address
  function automatic int err_delta(input logic [7:0] c, input logic [7:0] a, input int nbits);
    int d = 0;
    if (nbits < 8) d = 1;
    else if (c != 8'h02 && c != 8'h03) d = 1;
    else begin
      if (nbits >= 16 && a >= 8'd4) d++;
      if (nbits < 24) d++;
    end
    return d;
  endfunction

  task automatic chk_err(input string tag);
`ifdef SPI_SLAVE_ERR_CNT_EN
    chk(tag, {24'h0, o_err_cnt}, (merr > 255) ? 32'hFF : merr);
`else
    merr = merr;
`endif
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(8);
    m = miso;
    sclk = 1'b1;
    wait_clk(8);
    sclk = 1'b0;
  endtask

  // Runs one frame of nbits (<=24) bits; returns miso sampled before every rising edge
  task automatic frame(input string tag, input logic [7:0] c, input logic [7:0] a,
                       input logic [7:0] d, input int nbits, output logic [23:0] cap);
    logic [23:0] w;
    bit commit;
    int s0;
    w = {c, a, d};
    cap = '0;
    commit = (c == 8'h02) && (a < 8'd4) && (nbits == 24);
    s0 = strobe_cnt;
    if (commit) mregs[a[1:0]] = d;
    merr += err_delta(c, a, nbits);
    cs = 1'b0;
    wait_clk(4);
    chk({tag, ".busy"}, {31'h0, o_busy}, 32'h1);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[23-i];
      wait_clk(8);
      cap[23-i] = miso;
      sclk = 1'b1;
      if (i == 23 && c == 8'h02) begin
        wait_clk(3);
        chk({tag, ".strobe_early"}, {31'h0, o_wr_strobe}, 32'h0);
        wait_clk(1);
        chk({tag, ".strobe"}, {31'h0, o_wr_strobe}, {31'h0, commit});
        chk({tag, ".regs_at_strobe"}, o_regs, exp_regs());
        if (commit) chk({tag, ".wr_addr"}, {24'h0, o_wr_addr}, {24'h0, a});
        wait_clk(4);
      end else begin
        wait_clk(8);
      end
      sclk = 1'b0;
    end
    wait_clk(8);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
    chk({tag, ".idle"}, {31'h0, o_busy}, 32'h0);
    chk({tag, ".regs"}, o_regs, exp_regs());
    chk({tag, ".nstrobe"}, strobe_cnt - s0, commit ? 32'h1 : 32'h0);
    chk_err({tag, ".err"});
  endtask

  initial begin
    logic [23:0] cap;
    logic        m;
    logic [7:0]  c, a, d;
    int          nb, s0;
    logic [7:0]  exp_rd;

    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    wait_clk(3);
    chk("rst.regs", o_regs, 32'h0);
    chk("rst.miso", {31'h0, miso}, 32'h0);
    chk("rst.busy", {31'h0, o_busy}, 32'h0);
    chk("rst.strobe", {31'h0, o_wr_strobe}, 32'h0);
    chk("rst.wr_addr", {24'h0, o_wr_addr}, 32'h0);
    chk_err("rst.err");
    rst_n = 1'b1;
    wait_clk(6);

    frame("wr1", 8'h02, 8'h01, 8'hC8, 24, cap);
    frame("rd1", 8'h03, 8'h01, 8'h00, 24, cap);
    chk("rd1.data", {24'h0, cap[7:0]}, 32'h0000_00C8);
    chk("rd1.hdr_miso", {8'h0, cap[23:8]}, 32'h0);

    frame("abort", 8'h02, 8'h02, 8'h55, 12, cap);
    frame("wr2", 8'h02, 8'h02, 8'h55, 24, cap);

    frame("unk", 8'h7F, 8'h00, 8'hFF, 24, cap);
    chk("unk.miso", {8'h0, cap}, 32'h0);
    frame("wr0", 8'h02, 8'h00, 8'hAA, 24, cap);

`ifdef SPI_SLAVE_ERR_CNT_EN
    merr = 0;
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    wait_clk(4);
`endif
    frame("oorw", 8'h02, 8'h09, 8'h33, 24, cap);
    frame("oorr", 8'h03, 8'h09, 8'h00, 24, cap);
    chk("oorr.miso", {8'h0, cap}, 32'h0);

    // Reset lands in the ADDRESS phase; the rest of that frame must be ignored
    frame("pre", 8'h02, 8'h03, 8'h77, 24, cap);
    s0 = strobe_cnt;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 12; i++) send_bit(((24'h02_01_C8 >> (23 - i)) & 24'h1) != 0, m);
    rst_n = 1'b0;
    wait_clk(2);
    chk("rstmid.regs", o_regs, 32'h0);
    chk("rstmid.busy", {31'h0, o_busy}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    merr = 0;
    for (int i = 12; i < 24; i++) send_bit(((24'h02_01_C8 >> (23 - i)) & 24'h1) != 0, m);
    wait_clk(4);
    chk("rstmid.busy_after", {31'h0, o_busy}, 32'h0);
    chk("rstmid.nstrobe", strobe_cnt - s0, 32'h0);
    chk("rstmid.regs_after", o_regs, 32'h0);
    cs = 1'b1;
    wait_clk(8);
    frame("post", 8'h02, 8'h03, 8'h5A, 24, cap);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    c = 8'h02;
        2:       c = 8'h03;
        default: c = 8'($urandom);
      endcase
      a  = 8'($urandom_range(0, 5));
      d  = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 23) : 24;
      exp_rd = (a < 8'd4) ? mregs[a[1:0]] : 8'h00;
      frame("rnd", c, a, d, nb, cap);
      if (c == 8'h03 && nb == 24) chk("rnd.rdata", {24'h0, cap[7:0]}, {24'h0, exp_rd});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
